// File: rtl/fft_peak_detect_pkg.sv
// Shared defaults and types for the FFT peak detector.
//   Default widths and sizes for the top-level parameters.
//   FSM state encoding for the frame tracker.
//   Depth of the magnitude pipeline.
package fft_peak_detect_pkg;

  localparam int DATA_W_DEF  = 14;
  localparam int PTS_W_DEF   = 11;
  localparam int FFT_PTS_DEF = 1024;
  localparam int MIN_BIN_DEF = 1;
  localparam int EXP_W_DEF   = 6;

  // Register stages inside fft_mag_sq (squares, then sum)
  localparam int MAG_STAGES  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

endpackage

// File: rtl/fft_peak_detect_mag_sq.sv
// fft_mag_sq: pipelined re^2 + im^2 with a sideband that travels with the beat.
//   clk, reset_n      clock, async active-low reset (clears valids only)
//   in_vld, re, im    input beat, signed components
//   sb_in             opaque per-beat sideband, delayed to match mag
//   out_vld, mag      result valid and unsigned magnitude squared (2*DATA_W bits)
//   sb_out            sideband aligned with mag
module fft_mag_sq
  import fft_peak_detect_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int SB_W   = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_vld,
  input  logic signed [DATA_W-1:0] re,
  input  logic signed [DATA_W-1:0] im,
  input  logic        [SB_W-1:0]   sb_in,
  output logic                     out_vld,
  output logic        [2*DATA_W-1:0] mag,
  output logic        [SB_W-1:0]   sb_out
);

  localparam int MW = 2 * DATA_W;

  logic [MAG_STAGES:1]           vld_pipe;
  logic [MAG_STAGES:1][SB_W-1:0] sb_pipe;
  logic signed [MW-1:0]          re_x, im_x;
  logic [MW-1:0]                 re_sq, im_sq, sum;

  // Squares are formed at full 2*DATA_W width; the largest, (-2^(DATA_W-1))^2,
  // still fits, and the sum of two of them fits unsigned.
  assign re_x = {{DATA_W{re[DATA_W-1]}}, re};
  assign im_x = {{DATA_W{im[DATA_W-1]}}, im};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_pipe <= '0;
    else          vld_pipe <= {vld_pipe[MAG_STAGES-1:1], in_vld};
  end

  always_ff @(posedge clk) begin
    re_sq      <= re_x * re_x;
    im_sq      <= im_x * im_x;
    sb_pipe[1] <= sb_in;
    sum        <= re_sq + im_sq;
    sb_pipe[2] <= sb_pipe[1];
  end

  assign out_vld = vld_pipe[MAG_STAGES];
  assign mag     = sum;
  assign sb_out  = sb_pipe[MAG_STAGES];

endmodule

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: finds the strongest positive-frequency bin of each FFT frame.
//   clk, reset_n                 clock, async active-low reset
//   source_*                     Avalon-ST FFT source beat (valid/sop/eop/error/real/imag/exp)
//   source_ready                 always 1 once out of reset
//   mag_threshold                peak_found compares the frame peak against this
//   peak_valid                   1-cycle pulse, peak_bin/mag/exp/found updated and held
//   frame_err                    1-cycle pulse, a frame was discarded
// Pipeline: input register -> fft_mag_sq (2 stages) -> max tracker / output
// registers, so results land on the 3rd edge after the eop beat is sampled.
// Frame verdicts (done/err) ride the pipeline with the beat, so a new frame can
// start right behind an eop without disturbing the previous result.
module fft_peak_detect
  import fft_peak_detect_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PTS_W   = PTS_W_DEF,
  parameter int FFT_PTS = FFT_PTS_DEF,
  parameter int MIN_BIN = MIN_BIN_DEF,
  parameter int EXP_W   = EXP_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     source_valid,
  input  logic                     source_sop,
  input  logic                     source_eop,
  input  logic [1:0]               source_error,
  input  logic signed [DATA_W-1:0] source_real,
  input  logic signed [DATA_W-1:0] source_imag,
  input  logic [EXP_W-1:0]         source_exp,
  output logic                     source_ready,
  input  logic [2*DATA_W-1:0]      mag_threshold,
  output logic                     peak_valid,
  output logic [PTS_W-1:0]         peak_bin,
  output logic [2*DATA_W-1:0]      peak_mag,
  output logic [EXP_W-1:0]         peak_exp,
  output logic                     peak_found,
  output logic                     frame_err
);

  localparam int MW = 2 * DATA_W;
  localparam logic [PTS_W-1:0] LAST    = PTS_W'(FFT_PTS - 1);
  localparam logic [PTS_W-1:0] HALF_M1 = PTS_W'(FFT_PTS / 2 - 1);
  localparam logic [PTS_W-1:0] MIN_B   = PTS_W'(MIN_BIN);

  typedef struct packed {
    logic [PTS_W-1:0] bin;
    logic             seed;  // first beat of a frame: restart the max search
    logic             done;  // good eop: publish the result
    logic             err;   // a frame was dropped on this beat
    logic [EXP_W-1:0] ex;    // frame exponent
  } sb_t;

  localparam int SB_W = $bits(sb_t);

  // ---------------- front end: frame FSM ----------------
  state_t            state, state_n;
  logic [PTS_W-1:0]  bin_cnt, cnt_n, idx;
  logic              bad_q, bad_n;
  logic [EXP_W-1:0]  exp_q, exp_n;
  logic              accept, in_frame, last_idx, frame_bad, ends, beat_ok;
  sb_t               sb_n;

  always_comb begin
    accept    = source_valid & source_ready;
    in_frame  = accept & (source_sop | (state == FRAME));
    idx       = source_sop ? '0 : bin_cnt;
    last_idx  = (idx == LAST);
    frame_bad = (~source_sop & bad_q) | (|source_error);
    ends      = in_frame & (source_eop | last_idx);
    beat_ok   = ends & source_eop & last_idx & ~frame_bad;

    state_n = state;
    cnt_n   = bin_cnt;
    bad_n   = bad_q;
    exp_n   = exp_q;
    if (in_frame) begin
      state_n = ends ? IDLE : FRAME;
      cnt_n   = ends ? '0 : idx + PTS_W'(1);
      bad_n   = ~ends & frame_bad;
      if (source_sop) exp_n = source_exp;
    end

    sb_n.bin  = idx;
    sb_n.seed = source_sop;
    sb_n.done = beat_ok;
    // sop while a frame is open drops the old one; this beat still starts the new one
    sb_n.err  = (source_sop & (state == FRAME)) | (ends & ~beat_ok);
    sb_n.ex   = exp_n;
  end

  logic                     s0_vld;
  logic signed [DATA_W-1:0] s0_re, s0_im;
  sb_t                      s0_sb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bin_cnt      <= '0;
      bad_q        <= 1'b0;
      exp_q        <= '0;
      source_ready <= 1'b0;
      s0_vld       <= 1'b0;
    end else begin
      state        <= state_n;
      bin_cnt      <= cnt_n;
      bad_q        <= bad_n;
      exp_q        <= exp_n;
      source_ready <= 1'b1;
      s0_vld       <= in_frame;
    end
  end

  always_ff @(posedge clk) begin
    s0_re <= source_real;
    s0_im <= source_imag;
    s0_sb <= sb_n;
  end

  // ---------------- magnitude ----------------
  logic          m_vld;
  logic [MW-1:0] m_mag;
  sb_t           m_sb;

  fft_mag_sq #(.DATA_W(DATA_W), .SB_W(SB_W)) u_mag (
    .clk     (clk),
    .reset_n (reset_n),
    .in_vld  (s0_vld),
    .re      (s0_re),
    .im      (s0_im),
    .sb_in   (s0_sb),
    .out_vld (m_vld),
    .mag     (m_mag),
    .sb_out  (m_sb)
  );

  // ---------------- max tracker / outputs ----------------
  logic [MW-1:0]    max_mag, base_mag, new_mag;
  logic [PTS_W-1:0] max_bin, base_bin, new_bin;
  logic             in_range;

  // Seed of MIN_BIN/0 with strict '>' gives lowest-index tie wins and
  // MIN_BIN for an all-zero frame.
  always_comb begin
    base_mag = m_sb.seed ? '0 : max_mag;
    base_bin = m_sb.seed ? MIN_B : max_bin;
    in_range = (m_sb.bin >= MIN_B) && (m_sb.bin <= HALF_M1);
    new_mag  = base_mag;
    new_bin  = base_bin;
    if (in_range && (m_mag > base_mag)) begin
      new_mag = m_mag;
      new_bin = m_sb.bin;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_mag    <= '0;
      max_bin    <= '0;
      peak_valid <= 1'b0;
      frame_err  <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_exp   <= '0;
      peak_found <= 1'b0;
    end else begin
      peak_valid <= m_vld & m_sb.done;
      frame_err  <= m_vld & m_sb.err;
      if (m_vld) begin
        max_mag <= new_mag;
        max_bin <= new_bin;
      end
      if (m_vld & m_sb.done) begin
        peak_bin   <= new_bin;
        peak_mag   <= new_mag;
        peak_exp   <= m_sb.ex;
        peak_found <= (new_mag >= mag_threshold);
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Testbench for fft_peak_detect: directed table of frames, hand-written
// frame-error / reset sequences, and randomized frames, all checked against a
// frame-level reference model (collects each frame, scans bins for the peak).
module tb_fft_peak_detect;

  localparam int DW = 14, PW = 11, NPTS = 1024, MINB = 1, EW = 6;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 source_valid, source_sop, source_eop;
  logic [1:0]           source_error;
  logic signed [DW-1:0] source_real, source_imag;
  logic [EW-1:0]        source_exp;
  logic                 source_ready;
  logic [2*DW-1:0]      mag_threshold;
  logic                 peak_valid, peak_found, frame_err;
  logic [PW-1:0]        peak_bin;
  logic [2*DW-1:0]      peak_mag;
  logic [EW-1:0]        peak_exp;

  fft_peak_detect #(.DATA_W(DW), .PTS_W(PW), .FFT_PTS(NPTS), .MIN_BIN(MINB), .EXP_W(EW)) dut (
    .clk(clk), .reset_n(reset_n),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_error(source_error), .source_real(source_real), .source_imag(source_imag),
    .source_exp(source_exp), .source_ready(source_ready), .mag_threshold(mag_threshold),
    .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_mag(peak_mag),
    .peak_exp(peak_exp), .peak_found(peak_found), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_err = 0;
  int pv_cnt = 0, fe_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit     is_peak;
    int     bin;
    longint mag;
    int     ex;
    bit     found;
    time    t_s;   // time of the edge that sampled the closing beat
  } ev_t;

  ev_t ev_q[$];
  bit  m_act;
  int  m_len, m_exp;
  bit  m_bad;
  int  m_re [NPTS], m_im [NPTS];

  task automatic push_err(input time t);
    ev_t e;
    e = '{is_peak: 1'b0, bin: 0, mag: 0, ex: 0, found: 1'b0, t_s: t};
    ev_q.push_back(e);
  endtask

  task automatic push_peak(input time t);
    ev_t    e;
    int     best = MINB;
    longint bm = 0, mg;
    for (int b = MINB; b < NPTS / 2; b++) begin
      mg = longint'(m_re[b]) * m_re[b] + longint'(m_im[b]) * m_im[b];
      if (mg > bm) begin bm = mg; best = b; end
    end
    e = '{is_peak: 1'b1, bin: best, mag: bm, ex: m_exp,
          found: (bm >= longint'(mag_threshold)), t_s: t};
    ev_q.push_back(e);
  endtask

  task automatic model_beat(input bit sop, input bit eop, input logic [1:0] err,
                            input int re, input int im, input int ex, input time t);
    if (!m_act && !sop) return;
    if (sop) begin
      if (m_act) push_err(t);
      m_act = 1; m_len = 0; m_bad = 0; m_exp = ex;
    end
    m_re[m_len] = re;
    m_im[m_len] = im;
    if (err != 2'b00) m_bad = 1;
    m_len++;
    if (eop || m_len == NPTS) begin
      m_act = 0;
      if (eop && m_len == NPTS && !m_bad) push_peak(t);
      else push_err(t);
    end
  endtask

  // Called at every falling edge: compares pulses against the model's events.
  task automatic monitor_step();
    ev_t e;
    bit  due;
    if (!reset_n) return;
    if (peak_valid) pv_cnt++;
    if (frame_err)  fe_cnt++;
    due = (ev_q.size() != 0) && (ev_q[0].t_s + 35 == $time);
    if (due) begin
      e = ev_q.pop_front();
      chk("mon_peak_valid", longint'(peak_valid), longint'(e.is_peak));
      chk("mon_frame_err", longint'(frame_err), longint'(!e.is_peak));
      if (e.is_peak) begin
        chk("mon_bin", longint'(peak_bin), longint'(e.bin));
        chk("mon_mag", longint'(peak_mag), e.mag);
        chk("mon_exp", longint'(peak_exp), longint'(e.ex));
        chk("mon_found", longint'(peak_found), longint'(e.found));
      end
    end else if (peak_valid || frame_err) begin
      chk("mon_unexpected_pulse", longint'({peak_valid, frame_err}), 0);
    end
  endtask

  // ---------------- drivers ----------------
  int fr_re [1100], fr_im [1100];

  task automatic tick();
    @(negedge clk);
    monitor_step();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      source_valid = 1'b0;
      source_sop   = 1'($urandom);
      source_eop   = 1'($urandom);
      source_error = 2'($urandom);
      source_real  = 14'($urandom);
      source_imag  = 14'($urandom);
      source_exp   = 6'($urandom);
    end
  endtask

  task automatic beat(input bit sop, input bit eop, input logic [1:0] err,
                      input int re, input int im, input logic [EW-1:0] ex);
    tick();
    source_valid = 1'b1;
    source_sop   = sop;
    source_eop   = eop;
    source_error = err;
    source_real  = 14'(re);
    source_imag  = 14'(im);
    source_exp   = sop ? ex : 6'($urandom);
    model_beat(sop, eop, err, int'(source_real), int'(source_imag), int'(ex), $time + 5);
  endtask

  task automatic send_frame(input int len, input int eop_at, input int err_at,
                            input logic [EW-1:0] ex, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      beat(i == 0, i == eop_at, (i == err_at) ? 2'b01 : 2'b00, fr_re[i], fr_im[i], ex);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 1100; i++) begin fr_re[i] = 0; fr_im[i] = 0; end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ready"}, longint'(source_ready), 0);
    chk({tag, "_pv"},    longint'(peak_valid), 0);
    chk({tag, "_fe"},    longint'(frame_err), 0);
    chk({tag, "_bin"},   longint'(peak_bin), 0);
    chk({tag, "_mag"},   longint'(peak_mag), 0);
    chk({tag, "_exp"},   longint'(peak_exp), 0);
    chk({tag, "_found"}, longint'(peak_found), 0);
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    source_valid = 1'b0;
    ev_q.delete();
    m_act = 0;
    tick();
    check_outputs_zero("reset");
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("ready_after_reset", longint'(source_ready), 1);
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [PW-1:0]        bin;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } spk_t;

  typedef struct packed {
    spk_t [3:0]      s;
    logic [EW-1:0]   ex;
    logic [2*DW-1:0] thr;
    logic            gaps;
    logic [PW-1:0]   ebin;
    logic [2*DW-1:0] emag;
    logic            efound;
  } vec_t;

  function automatic spk_t sp(input int b, input int r, input int i);
    sp.bin = 11'(b);
    sp.re  = 14'(r);
    sp.im  = 14'(i);
  endfunction

  vec_t tbl [9];
  int   pv0, fe0;
  spk_t z;

  initial begin
    reset_n = 1'b0;
    source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0; source_error = 2'b00;
    source_real = '0; source_imag = '0; source_exp = '0; mag_threshold = '0;
    m_act = 0;

    z = sp(0, 0, 0);
    tbl[0] = {sp(37, 1000, 0), z, z, z, 6'd5, 28'd0, 1'b0, 11'd37, 28'd1000000, 1'b1};
    tbl[1] = {sp(0, 8000, 0), sp(600, 5000, 5000), sp(10, 300, 400), sp(20, 300, 400),
              6'h3F, 28'd0, 1'b0, 11'd10, 28'd250000, 1'b1};
    tbl[2] = {sp(5, -8192, -8192), z, z, z, 6'h20, 28'd0, 1'b0, 11'd5, 28'd134217728, 1'b1};
    tbl[3] = {sp(37, 1000, 0), z, z, z, 6'd7, 28'd1000001, 1'b0, 11'd37, 28'd1000000, 1'b0};
    tbl[4] = {z, z, z, z, 6'd1, 28'd0, 1'b0, 11'd1, 28'd0, 1'b1};
    tbl[5] = {sp(511, 1, 1), sp(512, 100, 0), z, z, 6'd9, 28'd2, 1'b0, 11'd511, 28'd2, 1'b1};
    tbl[6] = {sp(1, 0, -3), sp(511, 3, 0), z, z, 6'd12, 28'd10, 1'b0, 11'd1, 28'd9, 1'b0};
    tbl[7] = {sp(0, 8191, 8191), sp(1023, 100, 0), z, z, 6'd2, 28'd0, 1'b0, 11'd1, 28'd0, 1'b1};
    tbl[8] = {sp(5, -8192, -8192), z, z, z, 6'h20, 28'd0, 1'b1, 11'd5, 28'd134217728, 1'b1};

    // reset state
    repeat (2) tick();
    check_outputs_zero("init");
    reset_n = 1'b1;
    tick();
    chk("ready_after_init", longint'(source_ready), 1);

    for (int v = 0; v < 9; v++) begin
      clear_frame();
      for (int k = 0; k < 4; k++)
        if (tbl[v].s[k].re != 0 || tbl[v].s[k].im != 0) begin
          fr_re[tbl[v].s[k].bin] = int'(tbl[v].s[k].re);
          fr_im[tbl[v].s[k].bin] = int'(tbl[v].s[k].im);
        end
      mag_threshold = tbl[v].thr;
      pv0 = pv_cnt; fe0 = fe_cnt;
      send_frame(NPTS, NPTS - 1, -1, tbl[v].ex, tbl[v].gaps);
      idle(6);
      chk($sformatf("tbl%0d_pulses", v), longint'(pv_cnt - pv0), 1);
      chk($sformatf("tbl%0d_errs", v), longint'(fe_cnt - fe0), 0);
      chk($sformatf("tbl%0d_bin", v), longint'(peak_bin), longint'(tbl[v].ebin));
      chk($sformatf("tbl%0d_mag", v), longint'(peak_mag), longint'(tbl[v].emag));
      chk($sformatf("tbl%0d_exp", v), longint'(peak_exp), longint'(tbl[v].ex));
      chk($sformatf("tbl%0d_found", v), longint'(peak_found), longint'(tbl[v].efound));
    end

    // early eop at beat 500
    clear_frame(); fr_re[37] = 1000; mag_threshold = '0;
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_frame(501, 500, -1, 6'd3, 0); idle(6);
    chk("early_eop_pv", longint'(pv_cnt - pv0), 0);
    chk("early_eop_fe", longint'(fe_cnt - fe0), 1);

    // sop at beat 300 restarts; second frame reports
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_frame(300, -1, -1, 6'd4, 0);
    send_frame(NPTS, NPTS - 1, -1, 6'd11, 0); idle(6);
    chk("resop_fe", longint'(fe_cnt - fe0), 1);
    chk("resop_pv", longint'(pv_cnt - pv0), 1);
    chk("resop_bin", longint'(peak_bin), 37);
    chk("resop_exp", longint'(peak_exp), 11);

    // error beat 100
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_frame(NPTS, NPTS - 1, 100, 6'd6, 0); idle(6);
    chk("errbeat_pv", longint'(pv_cnt - pv0), 0);
    chk("errbeat_fe", longint'(fe_cnt - fe0), 1);

    // overrun: no eop at the last bin, trailing beats ignored
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_frame(1030, -1, -1, 6'd8, 0); idle(6);
    chk("overrun_pv", longint'(pv_cnt - pv0), 0);
    chk("overrun_fe", longint'(fe_cnt - fe0), 1);

    // back-to-back frames, sop right after eop
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_frame(NPTS, NPTS - 1, -1, 6'd21, 0);
    clear_frame(); fr_im[200] = -2000;
    send_frame(NPTS, NPTS - 1, -1, 6'd22, 0); idle(6);
    chk("b2b_pv", longint'(pv_cnt - pv0), 2);
    chk("b2b_fe", longint'(fe_cnt - fe0), 0);
    chk("b2b_bin", longint'(peak_bin), 200);
    chk("b2b_mag", longint'(peak_mag), 4000000);

    // reset at beat 400, then a clean frame
    clear_frame(); fr_re[77] = 1234; fr_im[77] = -55;
    send_frame(400, -1, -1, 6'd30, 0);
    do_reset();
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_frame(NPTS, NPTS - 1, -1, 6'd31, 0); idle(6);
    chk("postrst_pv", longint'(pv_cnt - pv0), 1);
    chk("postrst_fe", longint'(fe_cnt - fe0), 0);
    chk("postrst_bin", longint'(peak_bin), 77);

    // random frames with gaps and random thresholds
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 1100; i++) begin
        fr_re[i] = int'(14'sh0 + $signed(14'($urandom)));
        fr_im[i] = int'(14'sh0 + $signed(14'($urandom)));
      end
      mag_threshold = 28'($urandom_range(0, 134217728));
      send_frame(NPTS, NPTS - 1, (r == 3) ? 700 : -1, 6'($urandom), 1);
      idle(6);
    end
    chk("queue_drained", longint'(ev_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
